// File: rtl/pe_feeder.sv
// Feeds a 3x3 kernel column-by-column alongside a stream of image pixels to a PE.
// Each accepted pixel is registered together with the three kernel rows of the current column.
module pe_feeder #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              k_wr,
   input  logic [3:0]        k_addr,
   input  logic [DATA_W-1:0] k_data,
   input  logic              go,
   input  logic [LEN_W-1:0]  len,
   input  logic [2:0]        channel,
   input  logic [DATA_W-1:0] img_in,
   input  logic              img_in_valid,
   output logic              img_in_ready,
   output logic [DATA_W-1:0] weight1,
   output logic [DATA_W-1:0] weight2,
   output logic [DATA_W-1:0] weight3,
   output logic [DATA_W-1:0] img,
   output logic              start,
   output logic [2:0]        channel_packed,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [LEN_W-1:0]  cnt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_nxt;
   logic [1:0]        col;
   logic [3:0]        col_idx;
   logic [DATA_W-1:0] kern [0:8];

   assign img_in_ready = (state == S_RUN);
   assign busy         = (state == S_RUN);
   assign done         = (state == S_DONE);
   assign cnt_nxt      = cnt + LEN_W'(1);
   assign col_idx      = {2'b00, col};

   // Kernel is only writable between streams so a running stream sees a stable kernel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 9; i++) kern[i] <= '0;
      end else if (k_wr && (state == S_IDLE) && (k_addr <= 4'd8)) begin
         kern[k_addr] <= k_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         len_q          <= '0;
         col            <= '0;
         channel_packed <= '0;
         img            <= '0;
         weight1        <= '0;
         weight2        <= '0;
         weight3        <= '0;
         start          <= 1'b0;
         out_valid      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               out_valid <= 1'b0;
               start     <= 1'b0;
               if (go) begin
                  channel_packed <= channel;
                  len_q          <= len;
                  cnt            <= '0;
                  col            <= '0;
                  state          <= (len != '0) ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               if (img_in_valid) begin
                  img       <= img_in;
                  weight1   <= kern[col_idx];
                  weight2   <= kern[col_idx + 4'd3];
                  weight3   <= kern[col_idx + 4'd6];
                  out_valid <= 1'b1;
                  start     <= (cnt == '0);
                  col       <= (col == 2'd2) ? 2'd0 : col + 2'd1;
                  cnt       <= cnt_nxt;
                  if (cnt_nxt == len_q) state <= S_DONE;
               end else begin
                  // Stall: data outputs hold, only the qualifiers drop.
                  out_valid <= 1'b0;
                  start     <= 1'b0;
               end
            end
            S_DONE: begin
               out_valid <= 1'b0;
               start     <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized bench for pe_feeder: a stream-level model predicts each beat from kernel contents and beat index.
module tb_pe_feeder;

   logic       clk = 1'b0;
   logic       reset;
   logic       k_wr;
   logic [3:0] k_addr;
   logic [7:0] k_data;
   logic       go;
   logic [7:0] len;
   logic [2:0] channel;
   logic [7:0] img_in;
   logic       img_in_valid;
   logic       img_in_ready;
   logic [7:0] weight1, weight2, weight3, img;
   logic       start;
   logic [2:0] channel_packed;
   logic       out_valid, busy, done;

   int errs   = 0;
   int checks = 0;

   logic [7:0] exp_k [0:8];
   logic [2:0] exp_ch;
   logic [7:0] last_pix;
   logic [7:0] last_w1, last_w2, last_w3;

   pe_feeder #(.DATA_W(8), .LEN_W(8)) dut (
      .clk(clk), .reset(reset), .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data),
      .go(go), .len(len), .channel(channel), .img_in(img_in), .img_in_valid(img_in_valid),
      .img_in_ready(img_in_ready), .weight1(weight1), .weight2(weight2), .weight3(weight3),
      .img(img), .start(start), .channel_packed(channel_packed), .out_valid(out_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " weight1"}, weight1, 0);
      chk({tag, " weight2"}, weight2, 0);
      chk({tag, " weight3"}, weight3, 0);
      chk({tag, " img"}, img, 0);
      chk({tag, " channel_packed"}, channel_packed, 0);
      chk({tag, " ctrl"}, {start, out_valid, busy, done, img_in_ready}, 0);
   endtask

   task automatic kwrite(input logic [3:0] a, input logic [7:0] d);
      k_wr = 1'b1; k_addr = a; k_data = d;
      step();
      k_wr = 1'b0;
      if (a <= 4'd8) exp_k[a] = d;
   endtask

   task automatic load_kernel_seq();
      for (int i = 0; i < 9; i++) kwrite(4'(i), 8'(i + 1));
   endtask

   // Runs one stream; p_gap is the percentage of cycles with img_in_valid low.
   // Stray go pulses and kernel writes are injected during RUN and must have no effect.
   task automatic run_stream(input int n, input logic [2:0] ch, input int p_gap, input bit noise);
      int acc;
      int cyc;
      bit v;
      logic [7:0] pix;
      go = 1'b1; len = 8'(n); channel = ch;
      step();
      go = 1'b0;
      exp_ch = ch;
      chk("chan_on_go", channel_packed, exp_ch);
      if (n == 0) begin
         chk("len0 done", done, 1);
         chk("len0 busy/ovld/start", {busy, out_valid, start}, 0);
         step();
         chk("len0 after", {done, out_valid, start, busy}, 0);
         return;
      end
      chk("run busy", busy, 1);
      chk("run ready", img_in_ready, 1);
      chk("run first ovld", out_valid, 0);
      acc = 0;
      cyc = 0;
      while (acc < n) begin
         if (cyc > 4 * n + 50) begin
            chk("cycle budget", 0, 1);
            break;
         end
         cyc++;
         v = ($urandom_range(99) >= p_gap);
         pix = 8'($urandom);
         img_in_valid = v;
         img_in = pix;
         if (noise) begin
            go = ($urandom_range(3) == 0);
            channel = ~ch;
            len = 8'($urandom);
            k_wr = ($urandom_range(3) == 0);
            k_addr = 4'($urandom_range(8));
            k_data = 8'hFF;
         end
         step();
         go = 1'b0; k_wr = 1'b0;
         if (v) begin
            chk("beat ovld", out_valid, 1);
            chk("beat img", img, pix);
            chk("beat w1", weight1, exp_k[acc % 3]);
            chk("beat w2", weight2, exp_k[3 + acc % 3]);
            chk("beat w3", weight3, exp_k[6 + acc % 3]);
            chk("beat start", start, (acc == 0));
            last_pix = pix;
            last_w1 = exp_k[acc % 3];
            last_w2 = exp_k[3 + acc % 3];
            last_w3 = exp_k[6 + acc % 3];
            acc++;
         end else begin
            chk("stall ovld/start", {out_valid, start}, 0);
            if (acc > 0) begin
               chk("stall img hold", img, last_pix);
               chk("stall w hold", {weight1, weight2, weight3}, {last_w1, last_w2, last_w3});
            end
         end
         if (acc == n) begin
            chk("end done", done, 1);
            chk("end busy/ready", {busy, img_in_ready}, 0);
         end else begin
            chk("mid done", done, 0);
            chk("mid busy", busy, 1);
         end
         chk("chan hold", channel_packed, exp_ch);
      end
      img_in_valid = 1'b0;
      step();
      chk("idle after done", {done, out_valid, start, busy, img_in_ready}, 0);
      chk("idle chan hold", channel_packed, exp_ch);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      errs++;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; k_wr = 1'b0; k_addr = '0; k_data = '0; go = 1'b0; len = '0;
      channel = '0; img_in = '0; img_in_valid = 1'b0;
      for (int i = 0; i < 9; i++) exp_k[i] = '0;
      exp_ch = '0; last_pix = '0; last_w1 = '0; last_w2 = '0; last_w3 = '0;
      step(); step();
      chk_all_zero("reset");
      #3 reset = 1'b1;
      step();
      chk_all_zero("post reset idle");

      // Directed: kernel 1..9, continuous stream of six beats.
      load_kernel_seq();
      run_stream(6, 3'b001, 0, 0);
      // Stalls inside the stream, then the zero-length case.
      run_stream(6, 3'b110, 40, 0);
      run_stream(0, 3'b011, 0, 0);
      // Writes and go pulses during RUN are ignored; channel stays at 5.
      run_stream(9, 3'b101, 30, 1);
      run_stream(3, 3'b010, 0, 0);
      // Out-of-range kernel address in IDLE changes nothing.
      kwrite(4'd9, 8'hAA);
      kwrite(4'd15, 8'h55);
      run_stream(3, 3'b100, 0, 0);

      // Reset during beat 4 of a six-beat stream.
      go = 1'b1; len = 8'd6; channel = 3'b111;
      step();
      go = 1'b0;
      img_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         img_in = 8'(i + 1);
         step();
      end
      chk("pre-abort ovld", out_valid, 1);
      #2 reset = 1'b0;
      #1 chk_all_zero("async abort");
      img_in_valid = 1'b0;
      step();
      #3 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("no done after abort", {done, busy, out_valid}, 0);
      end
      for (int i = 0; i < 9; i++) exp_k[i] = '0;
      run_stream(3, 3'b011, 0, 0);
      load_kernel_seq();
      run_stream(3, 3'b001, 0, 0);

      // Randomized streams, including the maximum length.
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < 9; i++) kwrite(4'(i), 8'($urandom));
         run_stream($urandom_range(1, 20), 3'($urandom), $urandom_range(50), s[0]);
      end
      run_stream(255, 3'b110, 20, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter DATA_W, default 8, width of weight, image and kernel entries.
REQ-002 Parameter LEN_W, default 8, width of the stream-length field.
REQ-003 Clocking: one clock, clk; reset is asynchronous and active-low, port named reset.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 k_wr  input  1  kernel write strobe.
REQ-007 k_addr  input  4  kernel entry index 0..8, row-major (row*3+col).
REQ-008 k_data  input  DATA_W  kernel write data.
REQ-009 go  input  1  single-cycle request to start a stream.
REQ-010 len  input  LEN_W  number of image beats in the stream, sampled on go.
REQ-011 channel  input  3  channel tag, sampled on go.
REQ-012 img_in / img_in_valid  input  DATA_W / 1  upstream pixel and its valid.
REQ-013 img_in_ready  output  1  pixel accepted on any clk edge where img_in_valid and img_in_ready are both 1.
REQ-014 weight1, weight2, weight3  output  DATA_W each  kernel rows 0, 1, 2 of the current column, to the PE.
REQ-015 img  output  DATA_W  pixel to the PE.
REQ-016 start  output  1  one-cycle pulse on the first beat of a stream.
REQ-017 channel_packed  output  3  channel tag held for the stream.
REQ-018 out_valid  output  1  weight*/img carry a new beat this cycle.
REQ-019 busy / done  output  1 / 1  stream in progress / one-cycle completion pulse.

Function
REQ-020 Kernel store: 9 registers, DATA_W wide; written on k_wr only in IDLE with k_addr<=8; writes with k_addr>8, or writes in RUN/DONE, are ignored.
REQ-021 FSM states: IDLE, RUN, DONE; busy=1 only in RUN.
REQ-022 IDLE: img_in_ready=0, out_valid=0.
REQ-023 IDLE, go=1, len!=0: capture len and channel, clear beat counter cnt and column index col to 0, go to RUN.
REQ-024 IDLE, go=1, len==0: go to DONE; no beats issued.
REQ-025 RUN: img_in_ready=1 combinationally.
REQ-026 RUN accepted beat: next edge registers img<=img_in, weight1<=K[col], weight2<=K[3+col], weight3<=K[6+col], and sets out_valid<=1.
REQ-027 On the same beat: start<=(cnt==0); col wraps 0->1->2->0; cnt<=cnt+1.
REQ-028 Output latency is exactly one clk from acceptance.
REQ-029 RUN, img_in_valid=0 (stall): out_valid<=0, start<=0; img, weight*, col and cnt hold.
REQ-030 When the accepted beat makes cnt equal to the captured len, go to DONE on that edge.
REQ-031 DONE lasts one cycle: done=1, img_in_ready=0, out_valid<=0, start<=0, then IDLE.
REQ-032 go in RUN or DONE is ignored; a new go is honoured only in IDLE.
REQ-033 len=2^LEN_W-1 completes without counter wrap; cnt is LEN_W bits wide.
REQ-034 channel_packed updates only on accepted go and holds otherwise, including through IDLE.

Reset
REQ-035 reset low asynchronously forces: state IDLE, all kernel registers 0, cnt=0, col=0.
REQ-036 reset low also forces outputs weight*, img, channel_packed=0 and start, out_valid, busy, done, img_in_ready=0.
REQ-037 reset asserted mid-RUN aborts the stream; no done pulse is produced.
REQ-038 After reset releases, the first accepted go starts a fresh stream with col=0.

Verification
REQ-039 Kernel 1..9, go len=6, img_in_valid held high, img_in=1,2,3... -> weight1 1,2,3,1,2,3; weight2 4,5,6,4,5,6; weight3 7,8,9,7,8,9; img 1..6; start=1 on beat 1 only; done one cycle after beat 6.
REQ-040 Same setup, img_in_valid low for 2 cycles after beat 2 -> out_valid low 2 cycles; beat 3 shows weight1=3, img=3; no start re-pulse.
REQ-041 go with len=0 -> done=1 next cycle; out_valid and start never assert.
REQ-042 reset low at beat 4 of a len=6 stream -> all outputs 0 immediately, no done, kernel reads back 0. Then reload kernel and go len=3 -> start on beat 1, weight1=1.
REQ-043 k_wr during RUN with k_addr=0, k_data=0xFF -> ignored; next stream weight1 beat 1 = 1. k_wr in IDLE with k_addr=9 -> no kernel change.
REQ-044 go with channel=3'b101, then second go mid-RUN with channel=3'b010 -> channel_packed stays 5; second go has no effect on the stream.
